// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word-aligned imem requests and buffers returned
// instructions (tagged with their PC) in an in-order queue feeding decode.

package instr_fetch_unit_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fq_entry_t;

endpackage

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned OW  = $clog2(2 * DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] disc_q, disc_d;
  fq_entry_t     ent_q [DEPTH];
  fq_entry_t     ent_d [DEPTH];

  fq_entry_t head_ent;
  logic      req_valid_int;
  logic      id_valid_int;
  logic      issue;
  logic      pop;
  logic      rsp_drop;
  logic      rsp_fill;
  logic      rsp_used;

  // Handshake qualifiers; redirect suppresses issue, reset forces the request low.
  assign head_ent      = ent_q[head_q];
  assign req_valid_int = rst_n && (count_q < CW'(DEPTH)) && !redirect_valid;
  assign id_valid_int  = (count_q != '0) && head_ent.filled;
  assign issue         = req_valid_int && imem_req_ready;
  assign pop           = id_valid_int && id_ready;
  assign rsp_drop      = imem_rsp_valid && (disc_q != '0);
  assign rsp_fill      = imem_rsp_valid && (disc_q == '0) && (out_q != '0);
  assign rsp_used      = imem_rsp_valid && (out_q != '0);

  assign imem_req_valid = req_valid_int;
  assign imem_req_addr  = pc_q;
  assign id_valid       = id_valid_int;
  assign id_instr       = id_valid_int ? head_ent.instr : NOP;
  assign id_pc          = id_valid_int ? head_ent.pc : 32'h0;

  // Next-state: redirect flushes the queue and converts all in-flight responses to discards.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    out_d   = out_q;
    disc_d  = disc_q;
    ent_d   = ent_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_d[PW'(i)].filled = 1'b0;
      end
      out_d  = out_q - OW'(rsp_used);
      disc_d = out_d;
    end else begin
      if (issue) begin
        ent_d[tail_q].pc     = pc_q;
        ent_d[tail_q].instr  = NOP;
        ent_d[tail_q].filled = 1'b0;
        tail_d               = tail_q + PW'(1);
        pc_d                 = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        disc_d = disc_q - OW'(1);
      end
      if (rsp_fill) begin
        ent_d[fill_q].instr  = imem_rsp_data;
        ent_d[fill_q].filled = 1'b1;
        fill_d               = fill_q + PW'(1);
      end
      if (pop) begin
        ent_d[head_q].filled = 1'b0;
        head_d               = head_q + PW'(1);
      end
      out_d   = out_q + OW'(issue) - OW'(rsp_drop || rsp_fill);
      count_d = count_q + CW'(issue) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      out_q   <= '0;
      disc_q  <= '0;
      ent_q   <= '{default: '0};
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      ent_q   <= ent_d;
    end
  end

  // A response with nothing in flight is a memory-side protocol violation.
  always_ff @(posedge clk) begin
    if (rst_n && imem_rsp_valid) begin
      assert (out_q != '0) else $error("imem response received with no request outstanding");
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model and a delivery scoreboard.

module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend[$];
  int          errors = 0;
  int          checks = 0;
  int          n_acc  = 0;
  int          n_pop  = 0;
  bit          mem_en = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_ready      (id_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return {a[19:0], 12'h093};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_drive();
    imem_rsp_valid = mem_en && (pend.size() != 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(pend[0]) : 32'h0;
  endtask

  // One clock: sample handshakes mid-cycle, then advance the memory model after the edge.
  task automatic tick();
    logic        acc;
    logic        rsp;
    logic        popped;
    logic [31:0] a;
    exp_t        e;
    @(negedge clk);
    acc    = imem_req_valid && imem_req_ready;
    a      = imem_req_addr;
    rsp    = imem_rsp_valid;
    popped = id_valid && id_ready && !redirect_valid;
    if (popped) begin
      n_pop++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed id_pc=%h expected no delivery", id_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_instr", id_instr, e.instr);
      end
    end
    if (redirect_valid) exp_q.delete();
    if (acc) begin
      n_acc++;
      chk("req_align", 32'(a[1:0]), 32'h0);
      exp_q.push_back('{pc: a, instr: mem_word(a)});
    end
    @(posedge clk);
    #1;
    if (rsp) void'(pend.pop_front());
    if (acc) pend.push_back(a);
    mem_drive();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    pend.delete();
    exp_q.delete();
    mem_drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_acc = 0;
    n_pop = 0;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int k = 0;
    while (!id_valid && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, 32'(id_valid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    mem_en         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic streaming with a 1-cycle memory
    tick();
    chk("t1_valid_early", 32'(id_valid), 32'h0);
    chk("t1_addr_after_first", imem_req_addr, 32'h4);
    tick();
    chk("t1_first_valid", 32'(id_valid), 32'h1);
    chk("t1_first_pc", id_pc, 32'h0);
    chk("t1_first_instr", id_instr, 32'h0050_0093);
    tick();
    chk("t1_second_pc", id_pc, 32'h4);
    chk("t1_second_instr", id_instr, 32'h00A0_0113);
    chk("t1_third_addr", imem_req_addr, 32'h8);
    repeat (6) tick();

    // Decode stalled: credit limit caps issue at DEPTH
    id_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("t2_issue_count", 32'(n_acc), 32'd2);
    chk("t2_req_blocked", 32'(imem_req_valid), 32'h0);
    chk("t2_head_pc", id_pc, 32'h0);
    id_ready = 1'b1;
    tick();
    chk("t2_pop1_next_pc", id_pc, 32'h4);
    tick();
    chk("t2_issue_resumed", 32'(n_acc), 32'd3);
    chk("t2_pops", 32'(n_pop), 32'd2);
    repeat (6) tick();

    // Memory back-pressure holds the PC
    do_reset();
    tick();
    tick();
    imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t3_addr_hold", imem_req_addr, 32'h8);
    end
    chk("t3_drained", 32'(id_valid), 32'h0);
    chk("t3_no_issue", 32'(n_acc), 32'd2);
    chk("t3_req_valid", 32'(imem_req_valid), 32'h1);

    // Redirect with two outstanding requests; one response lands in the redirect cycle
    mem_en         = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    chk("t4_acc8", 32'(n_acc), 32'd3);
    chk("t4_addr_c", imem_req_addr, 32'hC);
    tick();
    chk("t4_accc", 32'(n_acc), 32'd4);
    chk("t4_full", 32'(imem_req_valid), 32'h0);
    mem_en = 1'b1;
    mem_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0101;
    #1;
    chk("t4_redirect_blocks_req", 32'(imem_req_valid), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_post_redirect_valid", 32'(id_valid), 32'h0);
    chk("t4_new_addr", imem_req_addr, 32'h0000_0100);
    chk("t4_new_req_valid", 32'(imem_req_valid), 32'h1);
    wait_valid(8, "t4_wait_valid");
    chk("t4_first_pc", id_pc, 32'h0000_0100);
    chk("t4_first_instr", id_instr, mem_word(32'h0000_0100));
    repeat (4) tick();

    // Redirect coincident with a pop and a response, then a back-to-back redirect
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    chk("t5_pop_offered", 32'(id_valid), 32'h1);
    tick();
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t5_queue_empty", 32'(id_valid), 32'h0);
    chk("t5_last_redirect_wins", imem_req_addr, 32'h0000_0300);
    chk("t5_no_pop_in_redirect", 32'(n_pop), 32'd0);
    wait_valid(8, "t5_wait_valid");
    chk("t5_first_pc", id_pc, 32'h0000_0300);
    repeat (4) tick();

    // Asynchronous reset with a full queue
    id_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("t6_full_valid", 32'(id_valid), 32'h1);
    chk("t6_full_pc", id_pc, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req_valid", 32'(imem_req_valid), 32'h0);
    chk("t6_async_id_valid", 32'(id_valid), 32'h0);
    chk("t6_async_id_instr", id_instr, NOP);
    chk("t6_async_id_pc", id_pc, 32'h0);
    do_reset();
    #1;
    chk("t6_restart_addr", imem_req_addr, RESET_PC);
    chk("t6_restart_valid", 32'(imem_req_valid), 32'h1);
    id_ready = 1'b1;
    wait_valid(8, "t6_wait_valid");
    chk("t6_restart_pc", id_pc, RESET_PC);

    // Drain: every accepted, unsquashed fetch must reach decode
    imem_req_ready = 1'b0;
    begin
      int k = 0;
      while (exp_q.size() != 0 && k < 20) begin
        tick();
        k++;
      end
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V core; sits directly upstream of decode and feeds the instruction word consumed by the immediate generator and control decode.
- Owns the PC register and issues word-aligned requests to instruction memory.
- Buffers returned instructions, each tagged with its PC, in a small in-order queue.
- Presents queued instructions to decode over a valid/ready handshake; handles redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, number of queue entries; power of two, minimum 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; bits [1:0] are always 0.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response data valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  control-flow redirect (taken branch, JAL, JALR, trap).
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- id_valid  out  1  head-of-queue instruction valid.
- id_instr  out  32  head instruction; 32'h0000_0013 (NOP) when id_valid = 0.
- id_pc  out  32  PC of the head instruction; 0 when id_valid = 0.
- id_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - pc = RESET_PC; queue empty; outstanding = 0; discard = 0.
  - imem_req_valid = 0, id_valid = 0, id_instr = 32'h0000_0013, id_pc = 0.
- Queue:
  - DEPTH entries, each holding {pc, instr, filled}; head and tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - An entry is allocated at request issue, not at response, so a returned response always has a reserved slot.
- Issue:
  - imem_req_valid = (count < DEPTH) && !redirect_valid.
  - imem_req_addr = pc.
  - On imem_req_valid && imem_req_ready:
    - allocate the tail entry with {pc, filled = 0};
    - pc <= pc + 4 (wraps modulo 2^32);
    - outstanding++.
- Response handling (imem_rsp_valid):
  - If discard > 0: drop the data, discard--, outstanding--.
  - Otherwise: write the data into the oldest unfilled entry, set filled = 1, outstanding--.
  - A response with outstanding == discard == 0 is a protocol error: assert in simulation, ignore in RTL.
- Delivery:
  - id_valid = count > 0 && head.filled.
  - On id_valid && id_ready: pop the head.
  - With no redirect: issue, fill, and pop may all occur in one cycle; count changes by (issue − pop).
  - A filled entry appears at the outputs the cycle after the response arrives; minimum request-to-id_valid latency is memory latency + 1.
- Redirect (redirect_valid = 1), highest priority:
  - The same cycle suppresses issue; any pop handshake in that cycle is ignored by the queue.
  - Next edge:
    - pc <= {redirect_pc[31:2], 2'b00};
    - queue cleared;
    - discard <= outstanding − (imem_rsp_valid ? 1 : 0);
    - outstanding <= that same value.
  - A response arriving in the redirect cycle is dropped.
  - id_valid is 0 the cycle after a redirect.
  - The first request to the new PC issues the cycle after the redirect if imem_req_ready = 1.
  - Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Credit rule: count (allocated entries) ≤ DEPTH at all times.
  - discard entries hold no queue slot, so up to DEPTH + discard responses may be in flight.
  - outstanding and discard counters are clog2(2*DEPTH)+1 bits wide.
- Reset mid-operation: all state returns immediately to reset values; any late memory responses are the memory's responsibility to squash.

Test Plan:
- Reset release, imem_req_ready = 1, 1-cycle memory returning words 0x00500093, 0x00A00113 → requests to 0x0, 0x4, 0x8…; id_pc = 0x0 with id_instr = 0x00500093, then id_pc = 0x4 with id_instr = 0x00A00113; id_valid first high 2 cycles after rst_n rises.
- id_ready held 0 for 5 cycles, DEPTH = 2 → exactly 2 requests issue (0x0, 0x4), then imem_req_valid = 0; on id_ready = 1 one pop per cycle, with a new issue each cycle.
- imem_req_ready = 0 for 3 cycles → imem_req_addr stays 0x8, pc does not advance, id_valid drops once the queue drains.
- 2 requests outstanding (0x8, 0xC), redirect_pc = 0x0000_0101 → next request addr = 0x0000_0100; both stale responses dropped; first id_pc = 0x100.
- Redirect asserted in the same cycle as a response and a pop → that response is dropped, queue empty, discard = outstanding − 1, no duplicate or lost instruction.
- rst_n pulsed low mid-stream with 2 queue entries valid → outputs go to reset values asynchronously; fetch restarts at RESET_PC.
